// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian words from a byte stream and
// writes them from BASE_ADDR upward. Define IMEM_LOADER_CHECKSUM_EN for the trailing-checksum check.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 64,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            load_len,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam int unsigned           AW1       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AW1-1:0]        LAST_BYTE = AW1'(MEM_DEPTH - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t     state, state_nxt;
    logic [1:0] byte_cnt;
    logic [7:0] word_cnt;
    logic [7:0] len;
    logic       fire;
    logic       last_byte;
    logic       last_word;
    logic       addr_ovf;
    logic       in_csum;

    assign fire      = byte_ready && byte_valid;
    assign last_byte = fire && (byte_cnt == 2'd3);
    assign last_word = ({1'b0, word_cnt} + 9'd1) == {1'b0, len};
    // Widened by one bit so the end-of-word address cannot wrap past the bound.
    assign addr_ovf  = ({1'b0, mem_addr} + AW1'(3)) > LAST_BYTE;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        csum_phase;
    logic [31:0] csum_sum;
    logic [23:0] csum_exp;
    logic        csum_ok;

    assign in_csum = csum_phase;
    // The fourth checksum byte is compared live as it arrives.
    assign csum_ok = (csum_sum == {byte_data, csum_exp});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_phase <= 1'b0;
            csum_sum   <= '0;
            csum_exp   <= '0;
        end else if (state == IDLE && start) begin
            csum_phase <= (load_len == 8'd0);
            csum_sum   <= '0;
        end else if (state == WRITE && !addr_ovf) begin
            csum_sum <= csum_sum + mem_wdata;
            if (last_word) csum_phase <= 1'b1;
        end else if (state == LOAD && fire && csum_phase) begin
            case (byte_cnt)
                2'd0:    csum_exp[7:0]   <= byte_data;
                2'd1:    csum_exp[15:8]  <= byte_data;
                2'd2:    csum_exp[23:16] <= byte_data;
                default: ;
            endcase
        end else if (state == DONE) begin
            csum_phase <= 1'b0;
        end
    end
`else
    assign in_csum = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (load_len == 8'd0 && !CSUM_EN) ? DONE : LOAD;
            LOAD: if (last_byte) state_nxt = in_csum ? DONE : WRITE;
            WRITE: begin
                if (addr_ovf)       state_nxt = DONE;
                else if (last_word) state_nxt = CSUM_EN ? LOAD : DONE;
                else                state_nxt = LOAD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == LOAD);
        mem_we     = (state == WRITE) && !addr_ovf;
        busy       = (state == LOAD) || (state == WRITE);
        cpu_hold   = (state == LOAD) || (state == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= BASE;
            mem_wdata <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            len       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len      <= load_len;
                    mem_addr <= BASE;
                    byte_cnt <= '0;
                    word_cnt <= '0;
                    err      <= 1'b0;
                    done     <= (load_len == 8'd0) && !CSUM_EN;
                end
                LOAD: if (fire) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (!in_csum) begin
                        case (byte_cnt)
                            2'd0:    mem_wdata[7:0]   <= byte_data;
                            2'd1:    mem_wdata[15:8]  <= byte_data;
                            2'd2:    mem_wdata[23:16] <= byte_data;
                            default: mem_wdata[31:24] <= byte_data;
                        endcase
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (last_byte && in_csum) begin
                        done <= csum_ok;
                        err  <= !csum_ok;
                    end
`endif
                end
                WRITE: begin
                    if (addr_ovf) begin
                        err <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 8'd1;
                        if (last_word) done <= !CSUM_EN;
                        else           mem_addr <= mem_addr + ADDR_WIDTH'(4);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; the expected write list and status flags
// come from a list-level model of the load rules.
module tb_imem_loader;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned MEM_DEPTH  = 64;
    localparam int unsigned BASE_ADDR  = 0;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [7:0]            load_len;
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] words_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_len  (load_len),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_we"},    mem_we, 0);
        chk({tag, "_addr"},  mem_addr, BASE_ADDR);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_hold"},  cpu_hold, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // Runs one load of words_q[0..len-1] and compares against the model.
    task automatic run_load(input string name, input int len, input int valid_pct,
                            input bit bad_csum, input int stall_at, input int inject_cyc,
                            input bit timed);
        logic [7:0]            bytes_q[$];
        logic [ADDR_WIDTH-1:0] exp_addr[$];
        logic [31:0]           exp_data[$];
        logic [ADDR_WIDTH-1:0] got_addr[$];
        logic [31:0]           got_data[$];
        logic [31:0]           sum;
        logic [31:0]           csum;
        logic [31:0]           w;
        longint                a;
        bit ovf, exp_done, exp_err, finished, take, stalling;
        int xfers, first_xfer, last_we, stall_left, end_cyc, n;

        sum = 0; ovf = 0; finished = 0; xfers = 0;
        first_xfer = -1; last_we = -1; stall_left = 7; end_cyc = -1;

        for (int i = 0; i < len; i++) begin
            a = longint'(BASE_ADDR) + 4 * i;
            if (a + 3 > longint'(MEM_DEPTH) - 1) begin
                ovf = 1;
                break;
            end
            exp_addr.push_back(ADDR_WIDTH'(a));
            exp_data.push_back(words_q[i]);
            sum += words_q[i];
        end
        for (int i = 0; i < len; i++) begin
            w = words_q[i];
            for (int b = 0; b < 4; b++) bytes_q.push_back(w[8*b +: 8]);
        end
        csum = bad_csum ? sum + 32'd1 : sum;
        if (CSUM_EN) for (int b = 0; b < 4; b++) bytes_q.push_back(csum[8*b +: 8]);
        if (ovf)          begin exp_done = 0;         exp_err = 1;        end
        else if (CSUM_EN) begin exp_done = !bad_csum; exp_err = bad_csum; end
        else              begin exp_done = 1;         exp_err = 0;        end

        @(posedge clk); #1;
        start = 1'b1;
        load_len = 8'(len);
        @(posedge clk); #1;
        start = 1'b0;
        load_len = 8'($urandom);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            stalling = 0;
            if (stall_at >= 0 && xfers == stall_at && stall_left > 0) begin
                byte_valid = 1'b0;
                stall_left--;
                stalling = 1;
            end else if (bytes_q.size() > 0 && $urandom_range(1, 100) <= valid_pct) begin
                byte_valid = 1'b1;
                byte_data = bytes_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data = 8'($urandom);
            end
            start = (cyc == inject_cyc);
            if (start) load_len = 8'($urandom_range(1, 255));
            @(negedge clk);
            if (stalling) chk({name, "_stall_ready"}, byte_ready, 1);
            take = byte_valid && byte_ready;
            if (take) begin
                if (first_xfer < 0) first_xfer = cyc;
                xfers++;
            end
            if (mem_we) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                last_we = cyc;
                chk({name, "_hold_on_write"}, cpu_hold, 1);
            end
            if (done || err) begin
                finished = 1;
                end_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            if (take) bytes_q.delete(0);
        end
        byte_valid = 1'b0;
        start = 1'b0;

        chk({name, "_finished"}, finished, 1);
        chk({name, "_nwrites"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", name, i), got_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
        end
        chk({name, "_done"}, done, exp_done);
        chk({name, "_err"},  err, exp_err);
        chk({name, "_busy_end"}, busy, 0);
        chk({name, "_hold_end"}, cpu_hold, 0);
        if (!ovf && finished) chk({name, "_bytes"}, xfers, 4 * len + (CSUM_EN ? 4 : 0));
        if (timed && len > 0 && !ovf) chk({name, "_cycles"}, last_we - first_xfer + 1, 5 * len);
        if (len == 0 && !CSUM_EN) chk({name, "_zero_latency"}, end_cyc, 0);
        @(posedge clk); #1;
        chk({name, "_done_held"}, done, exp_done);
        chk({name, "_err_held"},  err, exp_err);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        load_len = '0;
        byte_data = '0;
        byte_valid = 1'b0;
        #1;
        reset_check("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        words_q.delete();
        words_q.push_back(32'h01C80533);
        words_q.push_back(32'h403482B3);
        run_load("example", 2, 100, 0, -1, -1, 1);

        @(posedge clk); #1;
        start = 1'b1;
        load_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        @(posedge clk); #1;
        byte_data = 8'h5A;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        reset_check("midrst");
        @(posedge clk); #1 reset = 1'b1;
        rand_words(2);
        run_load("after_rst", 2, 100, 0, -1, -1, 1);

        rand_words(2);
        run_load("stall", 2, 100, 0, 2, -1, 0);

        rand_words(17);
        run_load("overflow", 17, 100, 0, -1, -1, 0);

        rand_words(16);
        run_load("full", 16, 100, 0, -1, -1, 1);

        words_q.delete();
        run_load("zero", 0, 100, 0, -1, -1, 0);

        rand_words(3);
        run_load("ign_start", 3, 100, 0, -1, 3, 1);

        words_q.delete();
        words_q.push_back(32'h00000013);
        run_load("csum_good", 1, 100, 0, -1, -1, 1);
        run_load("csum_bad", 1, 100, 1, -1, -1, 1);

        for (int t = 0; t < 10; t++) begin
            int l;
            l = $urandom_range(0, 8);
            rand_words(l);
            run_load($sformatf("rand%0d", t), l, $urandom_range(40, 100),
                     1'($urandom_range(0, 1)), -1, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the processor's instruction memory. It takes a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written to the byte-addressed instruction store at BASE_ADDR, BASE_ADDR+4, and so on. While loading, it holds the core in reset-equivalent stall. When loading finishes, the core is released to fetch from PC 0.

Parameters:
ADDR_WIDTH, 32, width of mem_addr (matches the fetch read_address width)
MEM_DEPTH, 64, number of instruction-store entries; entries are indexed by byte address
BASE_ADDR, 0, byte address of the first word written; must be a multiple of 4

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
load_len  input  8  number of 32-bit words to load; sampled when start is accepted
byte_data  input  8  incoming program byte
byte_valid  input  1  byte_data is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  write strobe to the instruction store, one cycle per word
mem_addr  output  ADDR_WIDTH  byte address of the word being written
mem_wdata  output  32  assembled instruction word
cpu_hold  output  1  high while a load is in progress; core PC is held
busy  output  1  high in LOAD or WRITE
done  output  1  sticky; set on successful completion, cleared by the next start
err  output  1  sticky; overflow (or checksum) error, cleared by the next start

Behaviour:
- Reset (reset=0, async). State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=0, busy=0, done=0, err=0.
  - Byte counter, word counter and partial word are cleared.
- Reset asserted mid-load: the partial word is discarded and no further writes occur. Words already written stay in memory.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start=1 with load_len=0: go to DONE, done=1, no writes.
  - start=1 with load_len>0: latch load_len, set mem_addr=BASE_ADDR, clear done and err, go to LOAD. cpu_hold rises in the same edge.
- LOAD:
  - byte_ready=1.
  - A byte transfers on a cycle where byte_valid & byte_ready are both 1.
  - Byte k of a word (k=0..3) goes into mem_wdata[8k+7:8k], so the first byte received is the LSB.
  - When the 4th byte transfers, go to WRITE.
- WRITE (exactly 1 cycle):
  - mem_we=1, byte_ready=0. mem_addr and mem_wdata are stable.
  - Next state:
    - Word count reached load_len: go to DONE.
    - Otherwise: mem_addr += 4, then go to LOAD.
- Overflow check: if a word would be written where mem_addr+3 > MEM_DEPTH-1:
  - No write occurs and err=1.
  - Go to DONE with done=0.
  - Remaining input bytes are not accepted.
- DONE:
  - cpu_hold=0, busy=0, byte_ready=0.
  - Returns to IDLE on the next cycle; done and err stay held.
- Throughput: one word per 5 cycles with byte_valid held high (4 LOAD + 1 WRITE).
- byte_valid low stalls LOAD indefinitely. There is no timeout.
- start while busy is ignored.
- Address arithmetic is ADDR_WIDTH-bit unsigned. mem_addr is always word-aligned.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, the loader accepts 4 more bytes (little-endian) as an expected checksum. These bytes are not written to memory.
  - The running checksum is the 32-bit modulo-2^32 sum of all written words.
  - On mismatch: err=1, done=0.
  - On match: done=1.
  - A zero-length load compares the checksum against 0.
- Not defined: no trailing bytes are consumed, and err flags overflow only.

Test Plan:
- Reset mid-load: assert reset after 2 bytes of word 1 -> all outputs at reset values immediately; after release, a new load starts cleanly at BASE_ADDR.
- Normal load, BASE_ADDR=0: start with load_len=2, bytes 33,05,C8,01,B3,82,34,40 -> mem_we pulses with (addr 0, 01C80533) then (addr 4, 403482B3). Then done=1, cpu_hold falls, and 10 cycles elapse from the first byte to the last write.
- Backpressure and stall: drop byte_valid for 7 cycles mid-word -> no extra byte is captured, byte_ready stays 1, and the word value is correct.
- Overflow: MEM_DEPTH=64, load_len=17 -> 16 writes (addresses 0..60); the 17th word is not written, err=1, done=0.
- Zero length and ignored start: load_len=0 -> done=1 the next cycle with no mem_we. A start pulse during LOAD leaves the state and counters unchanged.
- Checksum (with IMEM_LOADER_CHECKSUM_EN): 1 word 00000013 followed by checksum 13,00,00,00 -> done=1. A checksum of 14,00,00,00 -> err=1, done=0.
